// File: rtl/draw_scheduler_pkg.sv
// draw_scheduler_pkg: shared screen/sprite constants, ROM source codes and scheduler states
package draw_scheduler_pkg;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;
  localparam logic [11:0] TRANSP = 12'hF0F;
  localparam logic [1:0] SRC_START = 2'd0;
  localparam logic [1:0] SRC_GAME = 2'd1;
  localparam logic [1:0] SRC_SPR = 2'd3;
  typedef enum logic [1:0] {IDLE, BG, SPR, DRAIN} state_t;
  function automatic logic [14:0] scr_addr(input logic [7:0] x, input logic [6:0] y);
    return ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
  endfunction
endpackage

// File: rtl/draw_scheduler_pixel_pipe.sv
// pixel_pipe: delays pixel coordinates and plot flags so they line up with rom_q
module pixel_pipe #(
  parameter int LAT = 1,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [W:0] sr [LAT];
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < LAT; i++) sr[i] <= '0;
    end else begin
      sr[0] <= {in_valid, in_data};
      for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
    end
  assign {out_valid, out_data} = sr[LAT-1];
endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates background/sprite redraws and streams ROM pixels to the VGA adapter
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int SCREEN_W = SCR_W,
  parameter int SCREEN_H = SCR_H,
  parameter int SPR_W = SPRITE_W,
  parameter int SPR_H = SPRITE_H,
  parameter int ROM_LAT = 1,
  parameter logic [11:0] TRANSPARENT = TRANSP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bg_req,
  input  logic [1:0]  bg_sel,
  input  logic        spr_req,
  input  logic [7:0]  spr_x,
  input  logic [6:0]  spr_y,
  input  logic        spr_erase,
  output logic        bg_ack,
  output logic        spr_ack,
  output logic        busy,
  output logic        done,
  output logic [14:0] rom_addr,
  output logic [1:0]  rom_src,
  input  logic [11:0] rom_q,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [11:0] vga_colour,
  output logic        vga_plot
);
  state_t state, nxt;
  logic [7:0] cx, sx0, last_x, ix, dc;
  logic [6:0] cy, sy0, last_y, iy;
  logic [1:0] sel;
  logic [8:0] px;
  logic [7:0] py;
  logic [15:0] pd;
  logic erase, last_pix, accept, clip, iv, ikey, pv, drain_end;
  // no accept during the done pulse so a pending request is acked the cycle after
  assign accept = state == IDLE && !done && !reset;
  assign bg_ack = accept && bg_req;
  assign spr_ack = accept && spr_req && !bg_req;
  assign busy = state != IDLE;
  assign last_x = state == BG ? 8'(SCREEN_W - 1) : 8'(SPR_W - 1);
  assign last_y = state == BG ? 7'(SCREEN_H - 1) : 7'(SPR_H - 1);
  assign last_pix = cx == last_x && cy == last_y;
  assign drain_end = dc == 8'(ROM_LAT - 1);
  assign px = {1'b0, sx0} + {1'b0, cx};
  assign py = {1'b0, sy0} + {1'b0, cy};
  assign clip = px >= 9'(SCREEN_W) || py >= 8'(SCREEN_H);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bg_ack ? BG : spr_ack ? SPR : IDLE;
      BG, SPR: nxt = last_pix ? DRAIN : state;
      DRAIN: nxt = drain_end ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      cx <= '0;
      cy <= '0;
      dc <= '0;
      done <= 1'b0;
      sel <= '0;
      sx0 <= '0;
      sy0 <= '0;
      erase <= 1'b0;
    end else begin
      done <= state == DRAIN && drain_end;
      dc <= state == DRAIN ? dc + 8'd1 : 8'd0;
      if (bg_ack) sel <= bg_sel;
      if (spr_ack) begin
        sx0 <= spr_x;
        sy0 <= spr_y;
        erase <= spr_erase;
      end
      if (state == BG || state == SPR) begin
        cx <= cx == last_x ? 8'd0 : cx + 8'd1;
        if (cx == last_x) cy <= cy == last_y ? 7'd0 : cy + 7'd1;
      end
    end
  always_comb begin
    rom_src = state == BG ? sel : state == SPR ? (erase ? SRC_GAME : SRC_SPR) : SRC_START;
    rom_addr = state == BG ? scr_addr(cx, cy)
             : state != SPR ? 15'd0
             : !erase ? 15'(cy * SPR_W + cx)
             : clip ? 15'd0 : scr_addr(px[7:0], py[6:0]);
    iv = state == BG || (state == SPR && !clip);
    ikey = state == SPR && !erase;
    ix = state == BG ? cx : px[7:0];
    iy = state == BG ? cy : py[6:0];
  end
  pixel_pipe #(.LAT(ROM_LAT), .W(16)) u_pipe (
    .clk(clk),
    .rst(reset),
    .in_valid(iv),
    .in_data({ikey, ix, iy}),
    .out_valid(pv),
    .out_data(pd)
  );
  assign vga_x = pd[14:7];
  assign vga_y = pd[6:0];
  assign vga_plot = pv && !(pd[15] && rom_q == TRANSPARENT);
  assign vga_colour = vga_plot ? rom_q : 12'd0;
endmodule
